// File: rtl/tmds_pkg.sv
// Shared TMDS sink definitions: control tokens, token lookup, symbol balance and the
// alignment FSM state type.
package tmds_pkg;

  localparam logic [9:0] TokenCtrl00 = 10'b1101010100;
  localparam logic [9:0] TokenCtrl01 = 10'b0010101011;
  localparam logic [9:0] TokenCtrl10 = 10'b0101010100;
  localparam logic [9:0] TokenCtrl11 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch,
    StSlipWait,
    StLocked
  } align_state_e;

  typedef struct packed {
    logic       is_token;
    logic [1:0] ctrl;
  } token_info_t;

  function automatic token_info_t token_lookup(input logic [9:0] sym);
    token_info_t info;
    info = '{is_token: 1'b1, ctrl: 2'b00};
    case (sym)
      TokenCtrl00: info.ctrl = 2'b00;
      TokenCtrl01: info.ctrl = 2'b01;
      TokenCtrl10: info.ctrl = 2'b10;
      TokenCtrl11: info.ctrl = 2'b11;
      default:     info = '{is_token: 1'b0, ctrl: 2'b00};
    endcase
    return info;
  endfunction

  // Ones minus zeros of a 10-bit symbol, range -10..+10.
  function automatic logic signed [5:0] symbol_balance(input logic [9:0] sym);
    int ones;
    int bal;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      ones += int'(sym[i]);
    end
    bal = 2 * ones - 10;
    return bal[5:0];
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control-token detection plus the 10b->8b data inverse.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_is_token,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_data
);

  token_info_t info;
  logic [7:0]  q;
  logic [7:0]  x;

  always_comb begin
    info       = token_lookup(i_sym);
    o_is_token = info.is_token;
    o_ctrl     = info.ctrl;
    q          = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
    // x[k] = q[k] ^ q[k-1]; bit 0 of x is unused
    x          = q ^ {q[6:0], 1'b0};
    o_data     = {i_sym[8] ? x[7:1] : ~x[7:1], q[0]};
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with bitslip-driven symbol alignment and lock monitoring.
// Optional running-disparity checker enabled by defining TMDS_DISPARITY_CHECK_EN.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 4096,
  parameter int unsigned SLIP_SETTLE   = 4,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned DISP_LIMIT    = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_tmds,
  output logic [7:0] o_data,
  output logic [1:0] o_control,
  output logic       o_de,
  output logic       o_valid,
  output logic       o_locked,
  output logic       o_bitslip,
  output logic       o_disp_err
);

  localparam int unsigned RunW = $clog2(CTRL_RUN + 1);
  localparam int unsigned WinW = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned SetW = $clog2(SLIP_SETTLE + 1);
  localparam int unsigned TmoW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RunW-1:0] RunLast = RunW'(CTRL_RUN - 1);
  localparam logic [WinW-1:0] WinLast = WinW'(SEARCH_WINDOW - 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SLIP_SETTLE - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(LOCK_TIMEOUT - 1);

  logic [9:0]      sym_q;
  logic            is_token;
  logic [1:0]      dec_ctrl;
  logic [7:0]      dec_data;

  align_state_e    state_q, state_d;
  logic [RunW-1:0] run_q, run_d;
  logic [WinW-1:0] win_q, win_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            slip_d;
  logic            locked;
  logic            emit_data;

  logic [7:0]      data_q;
  logic [1:0]      ctrl_q;
  logic            de_q, valid_q, bitslip_q, disp_err_q;
  logic            disp_err_d;

  tmds_symbol_decode u_symbol_decode (
    .i_sym      (sym_q),
    .o_is_token (is_token),
    .o_ctrl     (dec_ctrl),
    .o_data     (dec_data)
  );

  assign locked    = (state_q == StLocked);
  assign emit_data = locked & ~is_token;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    win_d    = win_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    slip_d   = 1'b0;
    unique case (state_q)
      StSearch: begin
        run_d = is_token ? run_q + 1'b1 : '0;
        // Lock takes priority over a window expiring on the same symbol
        if (is_token && (run_q >= RunLast)) begin
          state_d = StLocked;
          run_d   = '0;
          win_d   = '0;
          tmo_d   = '0;
        end else if (win_q >= WinLast) begin
          state_d  = StSlipWait;
          slip_d   = 1'b1;
          run_d    = '0;
          win_d    = '0;
          settle_d = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      StSlipWait: begin
        if (settle_q >= SetLast) begin
          state_d  = StSearch;
          settle_d = '0;
          run_d    = '0;
          win_d    = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLocked: begin
        if (is_token) begin
          tmo_d = '0;
        end else if (tmo_q >= TmoLast) begin
          state_d = StSearch;
          tmo_d   = '0;
          run_d   = '0;
          win_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sym_q      <= '0;
      state_q    <= StSearch;
      run_q      <= '0;
      win_q      <= '0;
      settle_q   <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      ctrl_q     <= '0;
      de_q       <= 1'b0;
      valid_q    <= 1'b0;
      bitslip_q  <= 1'b0;
      disp_err_q <= 1'b0;
    end else begin
      sym_q      <= i_tmds;
      state_q    <= state_d;
      run_q      <= run_d;
      win_q      <= win_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      data_q     <= emit_data ? dec_data : '0;
      de_q       <= emit_data;
      valid_q    <= locked;
      bitslip_q  <= slip_d;
      disp_err_q <= disp_err_d;
      if (is_token) begin
        ctrl_q <= dec_ctrl;
      end
    end
  end

`ifdef TMDS_DISPARITY_CHECK_EN
  localparam logic signed [5:0] DispMax = 6'(DISP_LIMIT);

  logic signed [5:0] disp_q, disp_d, disp_sum;

  // Worst case before clearing is +/-(DispMax + 10), which still fits 6 bits
  always_comb begin
    disp_d     = disp_q;
    disp_err_d = 1'b0;
    disp_sum   = disp_q + symbol_balance(sym_q);
    if (is_token) begin
      disp_d = '0;
    end else if (locked) begin
      if ((disp_sum > DispMax) || (disp_sum < -DispMax)) begin
        disp_err_d = 1'b1;
        disp_d     = '0;
      end else begin
        disp_d = disp_sum;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_d;
    end
  end
`else
  logic unused_disp_limit;
  assign unused_disp_limit = ^DISP_LIMIT;
  assign disp_err_d        = 1'b0;
`endif

  assign o_data     = data_q;
  assign o_control  = ctrl_q;
  assign o_de       = de_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked;
  assign o_bitslip  = bitslip_q;
  assign o_disp_err = disp_err_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: cycle model of the decoder's observable behaviour plus directed checks.
module tb_tmds_decoder;

  localparam int CtrlRun      = 8;
  localparam int SearchWindow = 4096;
  localparam int SlipSettle   = 4;
  localparam int LockTimeout  = 4096;
  localparam int DispLimit    = 12;

  localparam int ModeSearch = 0;
  localparam int ModeSettle = 1;
  localparam int ModeLocked = 2;

  localparam logic [9:0] Tok00 = 10'b1101010100;
  localparam logic [9:0] Tok01 = 10'b0010101011;
  localparam logic [9:0] Tok10 = 10'b0101010100;
  localparam logic [9:0] Tok11 = 10'b1010101011;

  logic       i_clk;
  logic       i_rst_n;
  logic [9:0] i_tmds;
  logic [7:0] o_data;
  logic [1:0] o_control;
  logic       o_de, o_valid, o_locked, o_bitslip, o_disp_err;

  tmds_decoder #(
    .CTRL_RUN      (CtrlRun),
    .SEARCH_WINDOW (SearchWindow),
    .SLIP_SETTLE   (SlipSettle),
    .LOCK_TIMEOUT  (LockTimeout),
    .DISP_LIMIT    (DispLimit)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_tmds     (i_tmds),
    .o_data     (o_data),
    .o_control  (o_control),
    .o_de       (o_de),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_bitslip  (o_bitslip),
    .o_disp_err (o_disp_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_slip = 0;
  int cyc = 0;

  logic [9:0] tok_tbl [4] = '{Tok00, Tok01, Tok10, Tok11};

  function automatic bit ref_token(input logic [9:0] s, output logic [1:0] c);
    c = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (s == tok_tbl[i]) begin
        c = 2'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] ref_data(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[7:0];
    if (s[9]) q = ~q;
    d[0] = q[0];
    for (int k = 1; k < 8; k++) begin
      if (s[8]) d[k] = q[k] ^ q[k-1];
      else      d[k] = q[k] ~^ q[k-1];
    end
    return d;
  endfunction

  // Word seen by a deserializer offset by 'off' bits into a constant symbol stream
  function automatic logic [9:0] rot(input logic [9:0] s, input int off);
    logic [19:0] two;
    two = {s, s};
    return two[off +: 10];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: state after each clock edge
  bit         m_init = 1'b0;
  int         m_mode, m_run, m_win, m_settle, m_quiet, m_disp;
  logic [9:0] m_s1;
  bit         m_tok, m_was_locked;
  logic [1:0] m_c;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;
  logic       e_de, e_valid, e_locked, e_slip, e_derr;

  always @(posedge i_clk) begin
    cyc++;
    if (!i_rst_n) begin
      m_init = 1'b1;
      m_mode = ModeSearch;
      m_run = 0; m_win = 0; m_settle = 0; m_quiet = 0; m_disp = 0;
      m_s1 = '0;
      e_data = '0; e_ctrl = '0; e_de = 0; e_valid = 0; e_locked = 0; e_slip = 0; e_derr = 0;
    end else begin
      m_tok        = ref_token(m_s1, m_c);
      m_was_locked = (m_mode == ModeLocked);
      e_valid      = m_was_locked;
      e_de         = m_was_locked && !m_tok;
      e_data       = e_de ? ref_data(m_s1) : 8'h00;
      if (m_tok) e_ctrl = m_c;
      e_slip = 1'b0;
      e_derr = 1'b0;
`ifdef TMDS_DISPARITY_CHECK_EN
      if (m_tok) begin
        m_disp = 0;
      end else if (m_was_locked) begin
        m_disp += 2 * $countones(m_s1) - 10;
        if (m_disp > DispLimit || m_disp < -DispLimit) begin
          e_derr = 1'b1;
          m_disp = 0;
        end
      end
`endif
      case (m_mode)
        ModeSearch: begin
          m_win++;
          m_run = m_tok ? m_run + 1 : 0;
          if (m_run == CtrlRun) begin
            m_mode  = ModeLocked;
            m_quiet = 0;
          end else if (m_win == SearchWindow) begin
            m_mode   = ModeSettle;
            m_settle = 0;
            e_slip   = 1'b1;
          end
        end
        ModeSettle: begin
          m_settle++;
          if (m_settle == SlipSettle) begin
            m_mode = ModeSearch; m_run = 0; m_win = 0;
          end
        end
        default: begin
          m_quiet = m_tok ? 0 : m_quiet + 1;
          if (m_quiet == LockTimeout) begin
            m_mode = ModeSearch; m_run = 0; m_win = 0;
          end
        end
      endcase
      e_locked = (m_mode == ModeLocked);
      m_s1     = i_tmds;
    end
  end

  always @(negedge i_clk) begin
    if (m_init) begin
      chk("data", o_data, e_data);
      chk("control", o_control, e_ctrl);
      chk("de", o_de, e_de);
      chk("valid", o_valid, e_valid);
      chk("locked", o_locked, e_locked);
      chk("bitslip", o_bitslip, e_slip);
      chk("disp_err", o_disp_err, e_derr);
      if (o_bitslip === 1'b1) n_slip++;
    end
  end

  task automatic step(input logic [9:0] sym, input logic rst_n);
    @(negedge i_clk);
    i_tmds  = sym;
    i_rst_n = rst_n;
  endtask

  int off, slips_seen, last_slip, slips_before;

  initial begin
    i_rst_n = 1'b0;
    i_tmds  = '0;
    repeat (3) step(10'h000, 1'b0);
    chk("rst_locked", o_locked, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_bitslip", o_bitslip, 0);
    chk("rst_de_data", {o_de, o_data}, 0);
    chk("rst_control", o_control, 0);

    // First lock: the 8th token reaches the FSM one edge after it is registered
    repeat (9) step(Tok00, 1'b1);
    chk("lock_not_yet", o_locked, 0);
    step(Tok00, 1'b1);
    chk("lock_after_8", o_locked, 1);
    chk("lock_de", o_de, 0);
    chk("lock_control", o_control, 2'b00);

    repeat (2) step(Tok00, 1'b1);
    step(10'b0100000000, 1'b1);
    step(10'b1000000000, 1'b1);
    step(Tok00, 1'b1);
    chk("data_00", {o_valid, o_de, o_data}, {2'b11, 8'h00});
    step(Tok00, 1'b1);
    chk("data_ff", {o_valid, o_de, o_data}, {2'b11, 8'hFF});
    step(Tok00, 1'b1);
    chk("data_tok", {o_de, o_data}, 0);

    repeat (3) step(Tok01, 1'b1);
    chk("ctrl_01", {o_de, o_control}, 3'b001);
    repeat (3) step(Tok10, 1'b1);
    chk("ctrl_10", {o_de, o_control}, 3'b010);
    repeat (3) step(Tok11, 1'b1);
    chk("ctrl_11", {o_de, o_control}, 3'b011);

    // Two -8 symbols push |disparity| to 16
    step(10'b1000000000, 1'b1);
    step(10'b1000000000, 1'b1);
    step(Tok00, 1'b1);
    step(Tok00, 1'b1);
`ifdef TMDS_DISPARITY_CHECK_EN
    chk("disp_err_2nd", o_disp_err, 1);
`else
    chk("disp_err_off", o_disp_err, 0);
`endif
    step(Tok00, 1'b1);
    chk("disp_err_pulse", o_disp_err, 0);

    // Lock timeout on balanced data symbols (decode to 0x01)
    slips_before = n_slip;
    for (int i = 0; i < LockTimeout; i++) begin
      step(10'b1010101010, 1'b1);
      if (i == 2) chk("data_01", {o_de, o_data}, {1'b1, 8'h01});
    end
    step(10'b1010101010, 1'b1);
    chk("tmo_edge_locked", o_locked, 1);
    step(10'b1010101010, 1'b1);
    chk("tmo_dropped", o_locked, 0);
    step(10'b1010101010, 1'b1);
    chk("tmo_valid", o_valid, 0);
    chk("tmo_no_slip", n_slip - slips_before, 0);

    // Reset while locked
    repeat (12) step(Tok00, 1'b1);
    chk("relock", o_locked, 1);
    repeat (3) step(Tok11, 1'b1);
    step(Tok11, 1'b0);
    step(Tok11, 1'b1);
    chk("midreset_locked", o_locked, 0);
    chk("midreset_ctrl", {o_valid, o_control}, 0);

    // Misaligned by 3 bits; each bitslip request moves the source offset by one
    repeat (2) step(10'h000, 1'b0);
    off = 3;
    slips_seen = 0;
    last_slip = 0;
    step(rot(Tok00, off), 1'b1);
    for (int n = 0; n < 4 * (SearchWindow + SlipSettle) + 64 && !o_locked; n++) begin
      if (o_bitslip) begin
        if (slips_seen > 0) chk("slip_period", cyc - last_slip, SearchWindow + SlipSettle);
        last_slip = cyc;
        slips_seen++;
        off = (off == 0) ? 9 : off - 1;
      end
      step(rot(Tok00, off), 1'b1);
    end
    chk("rot_locked", o_locked, 1);
    chk("rot_slips", slips_seen, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
